grid_load_sequencer: RTL

//   Upstream control stage for the system memory. Accepts the initial grid as

---
 rtl/grid_seq_pkg.sv | 15 +
 rtl/grid_load_sequencer_word_serializer.sv | 55 +++++
 rtl/grid_load_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/grid_seq_pkg.sv
// Shared types and sizing helpers for the grid load sequencer.
package grid_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } seq_state_t;

  function automatic int unsigned bit_count_width(input int unsigned data_size);
    return $clog2(data_size + 1);
  endfunction

endpackage

// File: rtl/grid_load_sequencer_word_serializer.sv
// Parallel-in serial-out word buffer, LSB presented first on bit_out.
module word_serializer #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  bit_out,
  output logic                  empty,
  output logic                  last_bit,
  output logic                  empty_next,
  output logic                  last_bit_next
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load) begin
      data_d = word_in;
      cnt_d  = CNT_W'(WORD_WIDTH);
    end else if (shift && (cnt_q != '0)) begin
      data_d = data_q >> 1;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Look-ahead flags let the parent register its handshake outputs.
  assign bit_out       = data_q[0];
  assign empty         = (cnt_q == '0);
  assign last_bit      = (cnt_q == CNT_W'(1));
  assign empty_next    = (cnt_d == '0);
  assign last_bit_next = (cnt_d == CNT_W'(1));

endmodule

// File: rtl/grid_load_sequencer.sv
// Loads a grid into the cell memory bit-serially, then issues RUN_MODE
// strobes on STEP_TICK and counts generations.
module grid_load_sequencer
  import grid_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 25,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned GEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOAD_START,
  input  logic [WORD_WIDTH-1:0] WORD_IN,
  input  logic                  WORD_VALID,
  output logic                  WORD_READY,
  input  logic                  RUN_ENABLE,
  input  logic                  STEP_TICK,
  output logic                  SERIAL_OUT,
  output logic                  LOAD_MODE,
  output logic                  RUN_MODE,
  output logic                  LOADED,
  output logic [GEN_WIDTH-1:0]  GENERATION
);

  localparam int unsigned     CW         = bit_count_width(DATA_SIZE);
  localparam logic [CW-1:0]   LAST_CELL  = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0]   B2B_LIMIT  = CW'(DATA_SIZE - 2);

  seq_state_t           state_q, state_d;
  logic [CW-1:0]        cells_q, cells_d;
  logic                 loaded_q, loaded_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 word_ready_q, word_ready_d;
  logic                 load_mode_q, load_mode_d;
  logic                 run_mode_q, run_mode_d;

  logic ser_load, ser_shift, ser_flush;
  logic ser_bit, ser_empty, ser_last, ser_empty_next, ser_last_next;
  logic accept, consume;

  word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_ser (
    .clk          (CLK),
    .rst          (RESET),
    .load         (ser_load),
    .shift        (ser_shift),
    .flush        (ser_flush),
    .word_in      (WORD_IN),
    .bit_out      (ser_bit),
    .empty        (ser_empty),
    .last_bit     (ser_last),
    .empty_next   (ser_empty_next),
    .last_bit_next(ser_last_next)
  );

  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    loaded_d   = loaded_q;
    gen_d      = gen_q;
    run_mode_d = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_flush  = 1'b0;
    accept     = WORD_VALID && word_ready_q;
    consume    = 1'b0;

    case (state_q)
      IDLE: begin
        if (LOAD_START) state_d = LOAD;
      end
      LOAD: begin
        // The bit on SERIAL_OUT is taken by the memory at this edge; a new
        // word is only accepted once that bit is the buffer's last.
        consume   = !ser_empty;
        ser_load  = accept;
        ser_shift = consume && !accept;
        if (consume) cells_d = cells_q + CW'(1);
        if (consume && (cells_q == LAST_CELL)) begin
          state_d   = READY;
          loaded_d  = 1'b1;
          ser_flush = !ser_last;
        end
      end
      READY: begin
        if (LOAD_START)      state_d = LOAD;
        else if (RUN_ENABLE) state_d = RUN;
      end
      RUN: begin
        if (LOAD_START) begin
          state_d = LOAD;
        end else begin
          if (!RUN_ENABLE) state_d = READY;
          if (STEP_TICK) begin
            run_mode_d = 1'b1;
            if (gen_q != '1) gen_d = gen_q + GEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != LOAD) && (state_d == LOAD)) begin
      cells_d   = '0;
      loaded_d  = 1'b0;
      gen_d     = '0;
      ser_flush = 1'b1;
    end

    load_mode_d  = (state_d == LOAD) && !ser_empty_next;
    word_ready_d = (state_d == LOAD) &&
                   (ser_empty_next || (ser_last_next && (cells_d <= B2B_LIMIT)));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cells_q      <= '0;
      loaded_q     <= 1'b0;
      gen_q        <= '0;
      word_ready_q <= 1'b0;
      load_mode_q  <= 1'b0;
      run_mode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      loaded_q     <= loaded_d;
      gen_q        <= gen_d;
      word_ready_q <= word_ready_d;
      load_mode_q  <= load_mode_d;
      run_mode_q   <= run_mode_d;
    end
  end

  assign WORD_READY = word_ready_q;
  assign SERIAL_OUT = ser_bit;
  assign LOAD_MODE  = load_mode_q;
  assign RUN_MODE   = run_mode_q;
  assign LOADED     = loaded_q;
  assign GENERATION = gen_q;

endmodule
